// File: rtl/orient_kp_sched.sv
// orient_kp_sched: feeds column strips to the orientation unit, tags keypoints through its latency,
// and queues finished {x,y,cos,sin} records for the descriptor stage.
module orient_kp_sched #(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int LAT = 7,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_start,
  input  logic        i_col_valid,
  output logic        o_col_ready,
  input  logic [55:0] i_col,
  input  logic        i_kp,
  output logic        o_ori_valid,
  output logic [55:0] o_ori_col,
  input  logic [11:0] i_cos,
  input  logic [11:0] i_sin,
  output logic        o_kp_valid,
  input  logic        i_kp_ready,
  output logic [9:0]  o_kp_x,
  output logic [8:0]  o_kp_y,
  output logic [11:0] o_kp_cos,
  output logic [11:0] o_kp_sin,
  output logic        o_frame_done,
  output logic [7:0]  o_drop_cnt
);
  localparam int ROWS = HEIGHT - 6;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(LAT + 1);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  typedef struct packed {logic v; logic [9:0] x; logic [8:0] y;} tag_t;
  typedef struct packed {logic [9:0] x; logic [8:0] y; logic [11:0] c; logic [11:0] s;} rec_t;
  state_t state_q, state_d;
  logic [9:0] col_x_q, col_x_d;
  logic [8:0] strip_q, strip_d;
  logic [FW-1:0] flush_q, flush_d;
  tag_t tag_q [LAT];
  tag_t tag_d [LAT];
  rec_t mem_q [FIFO_DEPTH];
  rec_t mem_d [FIFO_DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0] drop_q, drop_d;
  logic done_q, done_d;
  logic accept, adv, empty, full, pop, push, last_col, last_strip;
  tag_t tag_in;
  rec_t head;
  assign accept = state_q == RUN && i_col_valid;
  assign adv = accept || state_q == FLUSH;
  assign empty = wr_q == rd_q;
  assign full = (wr_q - rd_q) == (AW + 1)'(FIFO_DEPTH);
  assign pop = !empty && i_kp_ready;
  assign push = adv && tag_q[LAT-1].v;
  assign last_col = col_x_q == 10'(WIDTH - 1);
  assign last_strip = strip_q == 9'(ROWS - 1);
  // the leftmost six columns of a strip belong to windows that straddle the previous strip
  assign tag_in = '{v: accept && i_kp && col_x_q >= 10'd6, x: col_x_q - 10'd3, y: strip_q + 9'd3};
  assign head = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign o_col_ready = state_q == RUN;
  assign o_ori_valid = adv;
  assign o_ori_col = state_q == RUN ? i_col : '0;
  assign o_kp_valid = !empty;
  assign {o_kp_x, o_kp_y, o_kp_cos, o_kp_sin} = head;
  assign o_frame_done = done_q;
  assign o_drop_cnt = drop_q;
  always_comb begin
    state_d = state_q;
    col_x_d = col_x_q;
    strip_d = strip_q;
    flush_d = flush_q;
    tag_d = tag_q;
    mem_d = mem_q;
    wr_d = wr_q;
    rd_d = rd_q + (AW + 1)'(pop);
    drop_d = drop_q;
    done_d = 1'b0;
    if (adv) begin
      tag_d[0] = tag_in;
      for (int i = 1; i < LAT; i++) tag_d[i] = tag_q[i-1];
    end
    if (push && (!full || pop)) begin
      mem_d[wr_q[AW-1:0]] = '{x: tag_q[LAT-1].x, y: tag_q[LAT-1].y, c: i_cos, s: i_sin};
      wr_d = wr_q + (AW + 1)'(1);
    end else if (push && drop_q != 8'hff) drop_d = drop_q + 8'd1;
    case (state_q)
      IDLE: if (i_frame_start) begin
        state_d = RUN;
        col_x_d = '0;
        strip_d = '0;
        drop_d = '0;
        tag_d = '{default: '0};
      end
      RUN: if (accept) begin
        col_x_d = last_col ? '0 : col_x_q + 10'd1;
        strip_d = last_col ? strip_q + 9'd1 : strip_q;
        state_d = last_col && last_strip ? FLUSH : RUN;
        flush_d = '0;
      end
      FLUSH: begin
        flush_d = flush_q + FW'(1);
        state_d = flush_q == FW'(LAT - 1) ? DONE : FLUSH;
      end
      DONE: if (empty) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      col_x_q <= '0;
      strip_q <= '0;
      flush_q <= '0;
      tag_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      drop_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_x_q <= col_x_d;
      strip_q <= strip_d;
      flush_q <= flush_d;
      tag_q <= tag_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      drop_q <= drop_d;
      done_q <= done_d;
    end
    mem_q <= mem_d;
  end
endmodule
